// File: rtl/nacc_sequencer.sv
// NACC sequencer: walks the weight lanes of one neuron-accumulate through a
// single shared 32-bit adder, stalling the front of the pipe until write-back.
module nacc_sequencer #(
  parameter int LANES    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            vl,
  input  logic [32*LANES-1:0]   wvr_data,
  input  logic [127:0]          svr_data,
  input  logic [31:0]           nsr_data,
  input  logic [4:0]            rd_in,
  input  logic                  flush,
  output logic                  stall,
  output logic                  busy,
  output logic [3:0]            lane_idx,
  output logic [31:0]           result,
  output logic [4:0]            result_rd,
  output logic                  result_valid,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_r;
  logic [32*LANES-1:0]   wvr_r;
  logic [LANES-1:0]      svr_r;
  logic [4:0]            rd_r;
  logic [4:0]            n_r;
  logic [3:0]            lane_r;
  logic [31:0]           acc_r;
  logic                  sticky_r;
  logic [31:0]           result_r;
  logic [4:0]            result_rd_r;
  logic                  result_valid_r;
  logic                  overflow_r;

  logic [31:0]           weight_s;
  logic                  spike_s;
  logic [32:0]           add_s;
  logic [31:0]           acc_next_s;
  logic                  clamp_s;
  logic                  last_s;
  logic                  unused_svr_s;

  // Lanes beyond LANES are never consumed.
  assign unused_svr_s = ^{1'b0, svr_data[127:LANES]};

  // Lane count 4*(vl+1), limited to the lanes actually present.
  function automatic logic [4:0] lane_count(input logic [1:0] code);
    logic [4:0] n;
    n = {1'b0, code, 2'b00} + 5'd4;
    if (n > 5'(LANES)) begin
      lane_count = 5'(LANES);
    end else begin
      lane_count = n;
    end
  endfunction

  // Returns {clamped, sum}; the clamp bit only ever rises when SATURATE is set.
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {a[31], a} + {b[31], b};
    if (SATURATE && (sum[32] != sum[31])) begin
      sat_add = {1'b1, (sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    end else begin
      sat_add = {1'b0, sum[31:0]};
    end
  endfunction

  // Select the current lane's weight and spike (one-hot OR mux).
  always_comb begin
    weight_s = 32'd0;
    spike_s  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      weight_s = weight_s | ((lane_r == 4'(i)) ? wvr_r[32*i +: 32] : 32'd0);
      spike_s  = spike_s  | ((lane_r == 4'(i)) & svr_r[i]);
    end
  end

  // Accumulate step for the current lane.
  always_comb begin
    add_s      = sat_add(acc_r, weight_s);
    acc_next_s = acc_r;
    clamp_s    = 1'b0;
    if (spike_s) begin
      acc_next_s = add_s[31:0];
      clamp_s    = add_s[32];
    end else begin
      acc_next_s = acc_r;
      clamp_s    = 1'b0;
    end
    last_s = ({1'b0, lane_r} == (n_r - 5'd1));
  end

  // Sequencer FSM with operand capture and registered write-back outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      wvr_r          <= '0;
      svr_r          <= '0;
      rd_r           <= 5'd0;
      n_r            <= 5'd0;
      lane_r         <= 4'd0;
      acc_r          <= 32'd0;
      sticky_r       <= 1'b0;
      result_r       <= 32'd0;
      result_rd_r    <= 5'd0;
      result_valid_r <= 1'b0;
      overflow_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          result_valid_r <= 1'b0;
          if (start && !flush) begin
            wvr_r    <= wvr_data;
            svr_r    <= svr_data[LANES-1:0];
            rd_r     <= rd_in;
            n_r      <= lane_count(vl);
            acc_r    <= nsr_data;
            lane_r   <= 4'd0;
            sticky_r <= 1'b0;
            state_r  <= RUN;
          end else begin
            state_r  <= IDLE;
          end
        end
        RUN: begin
          if (flush) begin
            lane_r  <= 4'd0;
            state_r <= IDLE;
          end else begin
            acc_r    <= acc_next_s;
            sticky_r <= sticky_r | clamp_s;
            if (last_s) begin
              // Commit on the way into DONE so the strobe lines up with the data.
              lane_r         <= 4'd0;
              result_r       <= acc_next_s;
              result_rd_r    <= rd_r;
              result_valid_r <= 1'b1;
              overflow_r     <= SATURATE & (sticky_r | clamp_s);
              state_r        <= DONE;
            end else begin
              lane_r  <= lane_r + 4'd1;
              state_r <= RUN;
            end
          end
        end
        DONE: begin
          result_valid_r <= 1'b0;
          state_r        <= IDLE;
        end
        default: begin
          result_valid_r <= 1'b0;
          lane_r         <= 4'd0;
          state_r        <= IDLE;
        end
      endcase
    end
  end

  // Stall must rise in the accepting cycle itself, so it looks at start directly.
  assign stall        = ((state_r == IDLE) & start & ~flush) | (state_r == RUN);
  assign busy         = (state_r == RUN) | (state_r == DONE);
  assign lane_idx     = (state_r == RUN) ? lane_r : 4'd0;
  assign result       = result_r;
  assign result_rd    = result_rd_r;
  assign result_valid = result_valid_r;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_nacc_sequencer.sv
// Bench for nacc_sequencer: saturating and wrapping instances driven in lockstep,
// a vector table feeding an expected-result queue, plus flush and reset sequences.
module tb_nacc_sequencer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   vl = 2'd0;
  logic [511:0] wvr = '0;
  logic [127:0] svr = '0;
  logic [31:0]  nsr = 32'd0;
  logic [4:0]   rd = 5'd0;

  logic         s_stall, s_busy, s_result_valid, s_overflow;
  logic [3:0]   s_lane_idx;
  logic [31:0]  s_result;
  logic [4:0]   s_result_rd;
  logic         w_stall, w_busy, w_result_valid, w_overflow;
  logic [3:0]   w_lane_idx;
  logic [31:0]  w_result;
  logic [4:0]   w_result_rd;

  int total = 0;
  int bad   = 0;

  nacc_sequencer #(.LANES(16), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .start(start), .vl(vl), .wvr_data(wvr), .svr_data(svr),
    .nsr_data(nsr), .rd_in(rd), .flush(flush), .stall(s_stall), .busy(s_busy),
    .lane_idx(s_lane_idx), .result(s_result), .result_rd(s_result_rd),
    .result_valid(s_result_valid), .overflow(s_overflow));

  nacc_sequencer #(.LANES(16), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .start(start), .vl(vl), .wvr_data(wvr), .svr_data(svr),
    .nsr_data(nsr), .rd_in(rd), .flush(flush), .stall(w_stall), .busy(w_busy),
    .lane_idx(w_lane_idx), .result(w_result), .result_rd(w_result_rd),
    .result_valid(w_result_valid), .overflow(w_overflow));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ovf;
    logic [31:0] wres;
  } sb_t;

  typedef struct {
    logic [1:0]   vl;
    logic [31:0]  nsr;
    logic [511:0] wvr;
    logic [15:0]  svr;
    logic [4:0]   rd;
    logic [31:0]  exp_sat;
    logic         exp_ovf;
    logic [31:0]  exp_wrap;
    logic         repulse;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference accumulate, written independently of the RTL structure.
  function automatic void model(input vec_t v, output logic [31:0] sres,
                                output logic sovf, output logic [31:0] wres);
    longint acc;
    logic [31:0] wacc;
    logic [31:0] w;
    acc  = longint'($signed(v.nsr));
    wacc = v.nsr;
    sovf = 1'b0;
    for (int i = 0; i < 4 * (int'(v.vl) + 1); i++) begin
      if (v.svr[i]) begin
        w    = v.wvr[32*i +: 32];
        acc  = acc + longint'($signed(w));
        wacc = wacc + w;
        if (acc > 64'sd2147483647) begin
          acc  = 64'sd2147483647;
          sovf = 1'b1;
        end else if (acc < -64'sd2147483648) begin
          acc  = -64'sd2147483648;
          sovf = 1'b1;
        end
      end
    end
    sres = acc[31:0];
    wres = wacc;
  endfunction

  task automatic sb_check();
    sb_t e;
    if (!reset && (s_result_valid || w_result_valid)) begin
      chk("valid_pair", {63'd0, s_result_valid}, {63'd0, w_result_valid});
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", {63'd0, s_result_valid | w_result_valid}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("result_sat", {32'd0, s_result}, {32'd0, e.res});
        chk("result_rd", {59'd0, s_result_rd}, {59'd0, e.rd});
        chk("overflow_sat", {63'd0, s_overflow}, {63'd0, e.ovf});
        chk("result_wrap", {32'd0, w_result}, {32'd0, e.wres});
        chk("overflow_wrap", {63'd0, w_overflow}, 64'd0);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb_check();
  endtask

  task automatic run_op(input vec_t v);
    sb_t e;
    int  n;
    n      = 4 * (int'(v.vl) + 1);
    e.res  = v.exp_sat;
    e.rd   = v.rd;
    e.ovf  = v.exp_ovf;
    e.wres = v.exp_wrap;
    sb_q.push_back(e);
    vl = v.vl; nsr = v.nsr; wvr = v.wvr; svr = {112'd0, v.svr}; rd = v.rd;
    start = 1'b1;
    #1 chk("stall_start", {63'd0, s_stall}, 64'd1);
    for (int k = 1; k <= n + 1; k++) begin
      tick();
      if (k == 1) begin
        // Scramble the operand inputs to prove they were captured.
        nsr = ~nsr; wvr = ~wvr; svr = ~svr; rd = ~rd;
      end
      start = v.repulse && (k == 3);
      if (k <= n) begin
        chk("run_status", {57'd0, s_stall, s_busy, s_lane_idx, s_result_valid},
            {57'd0, 1'b1, 1'b1, 4'(k - 1), 1'b0});
      end else begin
        chk("done_status", {57'd0, s_stall, s_busy, s_lane_idx, s_result_valid},
            {57'd0, 1'b0, 1'b1, 4'd0, 1'b1});
      end
    end
    start = 1'b0;
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    tick();
    chk("idle_after", {62'd0, s_busy, s_stall}, 64'd0);
  endtask

  initial begin
    vec_t        v;
    logic [31:0] last_res;
    logic [4:0]  last_rd;
    logic        last_ovf;

    // Table: directed rows with hand-computed expectations, then random rows.
    v = '{default: '0};
    v.vl = 2'd0; v.nsr = 32'd10; v.svr = 16'hFFFB; v.rd = 5'd7;
    for (int i = 0; i < 16; i++) v.wvr[32*i +: 32] = (i < 4) ? 32'(i + 1) : 32'h0000_1000;
    v.exp_sat = 32'd17; v.exp_ovf = 1'b0; v.exp_wrap = 32'd17;
    vecs[0] = v;

    v = '{default: '0};
    v.vl = 2'd3; v.nsr = 32'd0; v.svr = 16'hFFFF; v.rd = 5'd31; v.repulse = 1'b1;
    for (int i = 0; i < 16; i++) v.wvr[32*i +: 32] = 32'd1;
    v.exp_sat = 32'd16; v.exp_ovf = 1'b0; v.exp_wrap = 32'd16;
    vecs[1] = v;

    v = '{default: '0};
    v.vl = 2'd0; v.nsr = 32'h7FFF_FFF0; v.svr = 16'h0001; v.rd = 5'd3;
    v.wvr[31:0] = 32'h0000_0100;
    v.exp_sat = 32'h7FFF_FFFF; v.exp_ovf = 1'b1; v.exp_wrap = 32'h8000_00F0;
    vecs[2] = v;

    vecs[3] = vecs[0];
    vecs[3].rd = 5'd9;

    v = '{default: '0};
    v.vl = 2'd0; v.nsr = 32'h8000_0010; v.svr = 16'h0001; v.rd = 5'd4;
    v.wvr[31:0] = 32'hFFFF_FF00;
    v.exp_sat = 32'h8000_0000; v.exp_ovf = 1'b1; v.exp_wrap = 32'h7FFF_FF10;
    vecs[4] = v;

    for (int r = 5; r < 8; r++) begin
      v = '{default: '0};
      v.vl  = 2'($urandom_range(0, 3));
      v.nsr = $urandom;
      v.svr = 16'($urandom);
      v.rd  = 5'($urandom);
      for (int i = 0; i < 16; i++) v.wvr[32*i +: 32] = $urandom;
      model(v, v.exp_sat, v.exp_ovf, v.exp_wrap);
      vecs[r] = v;
    end

    // Reset state.
    #3;
    chk("reset_outputs", {19'd0, s_stall, s_busy, s_lane_idx, s_result, s_result_rd,
                          s_result_valid, s_overflow}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    for (int r = 0; r < 8; r++) run_op(vecs[r]);
    last_res = vecs[7].exp_sat;
    last_rd  = vecs[7].rd;
    last_ovf = vecs[7].exp_ovf;

    // Flush in the second RUN cycle of an 8-lane op.
    vl = 2'd1; nsr = 32'd100; svr = '1; rd = 5'd12;
    for (int i = 0; i < 16; i++) wvr[32*i +: 32] = 32'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("flush_pre", {59'd0, s_stall, s_lane_idx}, {59'd0, 1'b1, 4'd1});
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_idle", {62'd0, s_stall, s_busy}, 64'd0);
    chk("flush_hold", {26'd0, s_result, s_result_rd, s_overflow}, {26'd0, last_res, last_rd, last_ovf});
    for (int i = 0; i < 12; i++) tick();
    chk("flush_no_result", {32'd0, s_result}, {32'd0, last_res});

    // Start together with flush in IDLE is refused.
    start = 1'b1; flush = 1'b1;
    #1 chk("start_flush_stall", {63'd0, s_stall}, 64'd0);
    tick();
    start = 1'b0; flush = 1'b0;
    chk("start_flush_busy", {63'd0, s_busy}, 64'd0);
    run_op(vecs[0]);

    // Saturated op leaves overflow set, then reset mid-RUN clears everything.
    run_op(vecs[2]);
    vl = 2'd3; nsr = 32'd123; svr = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("async_reset_s", {19'd0, s_stall, s_busy, s_lane_idx, s_result, s_result_rd,
                          s_result_valid, s_overflow}, 64'd0);
    chk("async_reset_w", {19'd0, w_stall, w_busy, w_lane_idx, w_result, w_result_rd,
                          w_result_valid, w_overflow}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    v = '{default: '0};
    v.vl = 2'd0; v.nsr = 32'd5; v.svr = 16'h0000; v.rd = 5'd2;
    for (int i = 0; i < 16; i++) v.wvr[32*i +: 32] = 32'h0001_0000;
    v.exp_sat = 32'd5; v.exp_ovf = 1'b0; v.exp_wrap = 32'd5;
    run_op(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
